// File: rtl/aes_dram_pkg.sv
// Shared types and constants for the DRAM readout capture path.
package aes_dram_pkg;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SHIFT  = 2'd2,
    HOLD   = 2'd3
  } cap_state_e;

  localparam int AES_STATE_W = 128;
  localparam int ROUT_LANES  = 16;

  // MSB position of a lane's byte inside the AES state; lane 0 is the MSB byte.
  function automatic int lane_byte_msb(input int lane, input int bits);
    return AES_STATE_W - 1 - bits * lane;
  endfunction

endpackage

// File: rtl/rout_sync.sv
// Single-bit multi-flop synchronizer for one ROUT lane coming off the DRAM pads.
module rout_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw lane value through the synchronizer chain every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dram_rout_capture.sv
// Captures the 16 serial ROUT lanes into one 128-bit AES state and offers it
// downstream on a valid/ready handshake.
module dram_rout_capture
  import aes_dram_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int LANES         = ROUT_LANES,
  parameter int BITS_PER_LANE = 8
) (
  input  logic                             CLK,
  input  logic                             RSTn,
  input  logic                             cap_start,
  input  logic                             cap_abort,
  input  logic [LANES-1:0]                 rout,
  output logic [LANES*BITS_PER_LANE-1:0]   state_out,
  output logic                             state_vld,
  input  logic                             state_rdy,
  output logic                             busy,
  output logic                             cap_err,
  input  logic                             err_clr
);

  localparam int CNT_MAX = (SETTLE_CYCLES > BITS_PER_LANE) ? SETTLE_CYCLES : BITS_PER_LANE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(BITS_PER_LANE - 1);

  cap_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     capErr_q, capErr_d;
  logic                     shiftEn;
  logic                     errSet;
  logic [LANES-1:0]         syncRout;
  logic [BITS_PER_LANE-1:0] laneSr_q [LANES];

  // Per-lane synchronizer and placement of the lane byte in the AES state.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rout_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (CLK),
      .rst_ni (RSTn),
      .d_i    (rout[g]),
      .q_o    (syncRout[g])
    );
    assign state_out[lane_byte_msb(g, BITS_PER_LANE) -: BITS_PER_LANE] = laneSr_q[g];
  end

  // Next-state, counter and protocol-error decode; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shiftEn = 1'b0;
    errSet  = 1'b0;
    if (cap_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cap_start) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          errSet = cap_start;
          if (cnt_q == SETTLE_LAST) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          shiftEn = 1'b1;
          errSet  = cap_start;
          if (cnt_q == SHIFT_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (state_rdy) begin
            state_d = cap_start ? SETTLE : IDLE;
            cnt_d   = '0;
          end else begin
            errSet = cap_start;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sticky error: a new error beats a simultaneous clear; abort leaves it alone.
  always_comb begin
    capErr_d = capErr_q;
    if (!cap_abort) begin
      if (errSet)       capErr_d = 1'b1;
      else if (err_clr) capErr_d = 1'b0;
    end
  end

  // FSM state, counter and error flag registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      capErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      capErr_q <= capErr_d;
    end
  end

  // Lane shift registers: MSB-first shift in SHIFT, wiped on abort.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < LANES; i++) laneSr_q[i] <= '0;
    end else if (cap_abort) begin
      for (int i = 0; i < LANES; i++) laneSr_q[i] <= '0;
    end else if (shiftEn) begin
      for (int i = 0; i < LANES; i++)
        laneSr_q[i] <= {laneSr_q[i][BITS_PER_LANE-2:0], syncRout[i]};
    end
  end

  assign state_vld = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign cap_err   = capErr_q;

endmodule

// File: doc/dram_rout_capture.md
Name: dram_rout_capture

Overview:
- Captures the 16 serial readout lanes (ROUT_1v8_1..16) from the DRAM compute array after an in-array AddRoundKey/Sbox pass.
- Assembles the lanes into one 128-bit AES state and hands it to the FPGA-side ShiftRows/MixColumns logic over a valid/ready handshake.
- Sits directly downstream of the DRAM pads inside AES_DRAM_Top, clocked by the single-ended clock recovered from CLK_p/CLK_n.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per ROUT lane (>=2).
- SETTLE_CYCLES, 4, sense-amp settle wait after cap_start before the first sample (>=1).
- LANES, 16, ROUT lanes; fixed so that LANES*BITS_PER_LANE = 128.
- BITS_PER_LANE, 8, serial bits per lane, MSB first.

Ports:
- CLK  in  1  single system clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- cap_start  in  1  single-cycle request to capture one readout.
- cap_abort  in  1  synchronous abort; returns the block to IDLE.
- rout  in  16  raw ROUT lanes; bit0 = ROUT_1v8_1 … bit15 = ROUT_1v8_16.
- state_out  out  128  assembled state.
- state_vld  out  1  state_out valid.
- state_rdy  in  1  consumer accepts state_out.
- busy  out  1  high in SETTLE, SHIFT and HOLD.
- cap_err  out  1  sticky protocol-error flag.
- err_clr  in  1  clears cap_err.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, counters 0, shift registers 0, synchronizer flops 0. All outputs read 0.
- Synchronization: each rout bit passes through SYNC_STAGES flops continuously. A SHIFT sample at an edge sees the rout value from SYNC_STAGES edges earlier.
- FSM states: IDLE, SETTLE, SHIFT, HOLD.
- IDLE: if cap_start=1 at an edge, go to SETTLE and set cnt=0.
- SETTLE: cnt increments each edge. When cnt==SETTLE_CYCLES-1, go to SHIFT and set cnt=0.
- SHIFT, per edge:
  - Each lane shift register does lane_sr[i] <= {lane_sr[i][6:0], sync[i]}.
  - When cnt==7, go to HOLD and set state_vld=1 at that same edge.
- Latency: state_vld rises SETTLE_CYCLES+8 edges after the cap_start edge (12 at defaults).
- Byte mapping: lane i (0-based) maps to state_out[127-8i -: 8], so lane0 is the AES MSB byte.
- state_out is driven continuously from the shift registers. It is stable throughout HOLD.
- HOLD: state_vld=1. An edge with state_rdy=1 completes the transfer.
  - Transfer with cap_start=0: go to IDLE, state_vld=0.
  - Transfer with cap_start=1: go to SETTLE (back-to-back capture), state_vld=0.
- cap_start ignored: cap_start=1 in SETTLE, in SHIFT, or in HOLD with state_rdy=0 is ignored and sets cap_err.
- cap_err is sticky. err_clr=1 clears it. A new error in the same cycle as err_clr wins, so cap_err stays 1.
- cap_abort=1 in any state:
  - next state is IDLE; state_vld=0; shift registers and cnt are cleared;
  - cap_err is unchanged;
  - abort has priority over cap_start and state_rdy.
- state_rdy is ignored outside HOLD.
- busy = (state != IDLE).
- Reset mid-capture: immediate return to IDLE with all outputs 0. No partial data is retained.

Decomposition:
- Package aes_dram_pkg holds:
  - the FSM state enum {IDLE, SETTLE, SHIFT, HOLD};
  - AES_STATE_W=128;
  - constant ROUT_LANES=16;
  - lane-to-byte index function.
- Sub-module rout_sync (parameter STAGES): one-bit multi-flop synchronizer with async active-low reset, instantiated 16 times.

Test Plan:
- Reset: hold RSTn=0 with rout=16'hFFFF -> state_out=0, state_vld=0, busy=0, cap_err=0. After release, outputs remain 0 until cap_start.
- Basic capture:
  - Stimulus: lane i drives byte 0x11*i MSB-first, aligned to the sync delay; pulse cap_start with state_rdy=1.
  - Response: state_vld high exactly 12 edges after the start edge, with state_out=128'h00112233445566778899aabbccddeeff, for one cycle. Then IDLE, busy=0.
- Backpressure and error:
  - Stimulus: state_rdy=0 for 20 cycles in HOLD; pulse cap_start in HOLD.
  - Response: state_out stable, state_vld held, capture not restarted, cap_err=1. After err_clr, cap_err=0.
- Back-to-back:
  - Stimulus: cap_start together with state_rdy in HOLD; lanes now carry 0x00..0x0F.
  - Response: state_vld low for 12 edges, then state_out=128'h000102030405060708090a0b0c0d0e0f.
- Abort: cap_abort at the 3rd SHIFT edge -> IDLE next edge, busy=0, no state_vld. A following capture returns correct data.
- Async reset mid-SETTLE: RSTn low between clock edges -> outputs drop to 0 immediately. The next capture after release is correct.
